// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT RAM widths, read latency and arbiter enums
package fft_pkg;
  localparam int FFT_ADDR_W = 11;
  localparam int FFT_DATA_W = 28;
  localparam int FFT_RD_LAT = 2;
  typedef enum logic [1:0] {ARB, LOCK_WAIT, LOCKED} arb_state_t;
  typedef enum logic {OWN_DET, OWN_HOST} owner_t;
endpackage

// File: rtl/fft_ram_arbiter_rd_return_pipe.sv
// rd_return_pipe: {valid, owner} delay line that tags each RAM read until its data returns
module rd_return_pipe
  import fft_pkg::*;
#(
  parameter int DEPTH = FFT_RD_LAT + 1
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   in_valid,
  input  owner_t in_owner,
  output logic   out_valid,
  output owner_t out_owner,
  output logic   host_busy
);
  logic [DEPTH-1:0] valid_q, valid_d, host_q, host_d;
  always_comb begin
    valid_d = DEPTH'({valid_q, in_valid});
    host_d  = DEPTH'({host_q, in_owner == OWN_HOST});
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid_q <= '0;
      host_q  <= '0;
    end else begin
      valid_q <= valid_d;
      host_q  <= host_d;
    end
  assign out_valid = valid_q[DEPTH-1];
  assign out_owner = host_q[DEPTH-1] ? OWN_HOST : OWN_DET;
  assign host_busy = |(valid_q & host_q);
endmodule

// File: rtl/fft_ram_arbiter.sv
// fft_ram_arbiter: round-robin det/host arbiter for the FFT RAM read port; det lock sweep enabled by FFT_ARB_LOCK_EN
module fft_ram_arbiter
  import fft_pkg::*;
#(
  parameter int ADDR_W = FFT_ADDR_W,
  parameter int DATA_W = FFT_DATA_W,
  parameter int RD_LAT = FFT_RD_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              det_req,
  input  logic [ADDR_W-1:0] det_addr,
  output logic              det_gnt,
  output logic              det_rvalid,
  output logic [DATA_W-1:0] det_rdata,
  input  logic              det_lock,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ramaddr,
  input  logic [DATA_W-1:0] ramq,
  output logic              locked
);
  arb_state_t        state_q, state_d;
  owner_t            ptr_q, ptr_d, rown;
  logic              locked_q, locked_d, lock_in, host_elig, rv, host_busy;
  logic [ADDR_W-1:0] ramaddr_q, ramaddr_d;
  logic [DATA_W-1:0] det_hold_q, det_hold_d, host_hold_q, host_hold_d;
`ifdef FFT_ARB_LOCK_EN
  assign lock_in = det_lock;
`else
  logic unused_lock;
  assign unused_lock = det_lock | host_busy;
  assign lock_in = 1'b0;
`endif
  // a rising lock already blocks the host in the same cycle
  assign host_elig = host_req && state_q == ARB && !lock_in;
  assign det_gnt   = !reset && det_req && (!host_elig || ptr_q == OWN_DET);
  assign host_gnt  = !reset && host_elig && (!det_req || ptr_q == OWN_HOST);
  rd_return_pipe #(.DEPTH(RD_LAT + 1)) u_pipe (
    .clk(clk),
    .reset(reset),
    .in_valid(det_gnt | host_gnt),
    .in_owner(host_gnt ? OWN_HOST : OWN_DET),
    .out_valid(rv),
    .out_owner(rown),
    .host_busy(host_busy)
  );
  assign det_rvalid  = rv && rown == OWN_DET;
  assign host_rvalid = rv && rown == OWN_HOST;
  assign det_rdata   = det_rvalid ? ramq : det_hold_q;
  assign host_rdata  = host_rvalid ? ramq : host_hold_q;
  assign ramaddr     = ramaddr_q;
  assign locked      = locked_q;
  always_comb begin
    ramaddr_d   = host_gnt ? host_addr : det_gnt ? det_addr : ramaddr_q;
    ptr_d       = host_gnt ? OWN_DET : det_gnt ? OWN_HOST : ptr_q;
    det_hold_d  = det_rdata;
    host_hold_d = host_rdata;
    state_d     = state_q;
`ifdef FFT_ARB_LOCK_EN
    state_d = state_q == ARB ? (lock_in ? LOCK_WAIT : ARB) :
              !lock_in ? ARB :
              (state_q == LOCK_WAIT && !host_busy) ? LOCKED : state_q;
    ptr_d   = (state_q == LOCKED && !lock_in) ? OWN_HOST : ptr_d;
`endif
    locked_d = state_d == LOCKED;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= ARB;
      ptr_q       <= OWN_DET;
      locked_q    <= 1'b0;
      ramaddr_q   <= '0;
      det_hold_q  <= '0;
      host_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      locked_q    <= locked_d;
      ramaddr_q   <= ramaddr_d;
      det_hold_q  <= det_hold_d;
      host_hold_q <= host_hold_d;
    end
endmodule

// File: doc/fft_ram_arbiter.md
FFT_RAM_ARBITER -- requirements
Module: fft_ram_arbiter

Interface
REQ-001 The block SHALL have parameters ADDR_W, default 11, meaning the FFT RAM address width (2048 bins).
REQ-002 The block SHALL have parameters DATA_W, default 28, meaning the RAM word width ({real[27:14], imag[13:0]}).
REQ-003 The block SHALL have parameters RD_LAT, default 2, meaning the RAM read latency in clk cycles from address to ramq valid.
REQ-004 Ports: clk  in  1  single clock, 50 MHz.
REQ-005 Ports: reset  in  1  asynchronous, active-high reset.
REQ-006 Ports: det_req / det_addr / det_gnt  in / in / out  1 / ADDR_W / 1  detect-engine read request, address, grant pulse.
REQ-007 Ports: det_rvalid / det_rdata  out / out  1 / DATA_W  detect-engine read return.
REQ-008 Ports: det_lock  in  1  detect engine requests exclusive RAM access for a sweep.
REQ-009 Ports: host_req / host_addr / host_gnt  in / in / out  1 / ADDR_W / 1  host read request, address, grant pulse.
REQ-010 Ports: host_rvalid / host_rdata  out / out  1 / DATA_W  host read return.
REQ-011 Ports: ramaddr / ramq  out / in  ADDR_W / DATA_W  shared RAM read port.
REQ-012 Ports: locked  out  1  high while the lock is active.

Function
REQ-013 Requesters SHALL hold req and addr stable until a 1-cycle gnt; req dropped without gnt is legal (withdrawn).
REQ-014 At most one gnt SHALL be asserted per cycle; ramaddr SHALL be registered with the granted addr on the grant cycle edge.
REQ-015 Back-to-back issue: one grant per cycle sustained; no bubbles when requests are pending.
REQ-016 Arbitration in ARB state: round-robin; a 1-bit pointer favours the requester not granted last; a single requester is granted immediately.
REQ-017 Return routing: an RD_LAT+1 deep {valid, owner} shift pipeline SHALL assert the owner's rvalid exactly RD_LAT+1 cycles after its gnt, with rdata = ramq that cycle, in issue order.
REQ-018 rdata of the non-owner SHALL hold its last value; rvalid of the non-owner SHALL be 0.
REQ-019 FSM states: ARB, LOCK_WAIT, LOCKED.
REQ-020 ARB -> LOCK_WAIT on det_lock=1; in LOCK_WAIT, host is not granted and det is granted.
REQ-021 LOCK_WAIT -> LOCKED once no host read is in flight; locked=1 only in LOCKED.
REQ-022 LOCKED: only det is granted; LOCKED -> ARB when det_lock=0.
REQ-023 When det_lock rises in the same cycle as a lone host_req, the host SHALL NOT be granted.
REQ-024 host_req pending while LOCKED SHALL be granted first (pointer forced to host) on the cycle after return to ARB.
REQ-025 When ramaddr reaches 2^ADDR_W-1 and increments, it SHALL wrap to 0; the arbiter itself imposes no address ordering.

Reset
REQ-026 On reset: all gnt, rvalid, locked = 0; rdata = 0; ramaddr = 0; pipeline cleared; state = ARB; RR pointer favours det.
REQ-027 Reset mid-operation: in-flight reads are discarded; no rvalid SHALL be asserted for any read granted before reset.

Configuration
REQ-028 Macro FFT_ARB_LOCK_EN defined: det_lock and states LOCK_WAIT/LOCKED SHALL behave as above.
REQ-029 Macro FFT_ARB_LOCK_EN undefined: det_lock SHALL be ignored, the FSM SHALL remain in ARB, and locked SHALL be tied 0.

Structure
REQ-030 Shared package fft_pkg SHALL hold FFT_ADDR_W=11, FFT_DATA_W=28, FFT_RD_LAT=2, the arb_state_t enum and the owner_t enum (OWN_DET, OWN_HOST).
REQ-031 One sub-module, rd_return_pipe, SHALL implement the {valid, owner} delay line of depth RD_LAT+1.

Verification
REQ-032 Bench: det_req alone, addr 0x005 -> det_gnt in the same cycle; ramaddr=0x005 next; det_rvalid 3 cycles after gnt with the RAM word at 0x005.
REQ-033 Bench: det and host both requesting continuously, addresses 0x100/0x200 -> gnts alternate det, host, det...; 1 grant/cycle; returns correctly routed.
REQ-034 Bench: host read in flight (gnt at t), det_lock at t+1 -> LOCK_WAIT; host rvalid at t+3; locked=1 at t+3 or later; no host_gnt while locked.
REQ-035 Bench: det sweep 0x000..0x7FF under lock -> 2048 det_rvalid pulses in order; host_req held throughout is granted first after det_lock drops.
REQ-036 Bench: reset asserted asynchronously 1 cycle after 2 grants -> outputs 0 immediately; no rvalid afterwards; state ARB.
REQ-037 Bench: with FFT_ARB_LOCK_EN undefined, det_lock=1 and both requesting -> round-robin continues; locked stays 0.
